// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Operation codes shared by the SAP register bank and the controller
// microcode ROM.
// Contents: OPW (op-code width), op_t (op-code type), OP_NOP..OP_SWAP.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sap_pkg;

  localparam int OPW = 3;

  typedef logic [OPW-1:0] op_t;

  localparam op_t OP_NOP  = 3'd0;
  localparam op_t OP_LOAD = 3'd1;
  localparam op_t OP_CLR  = 3'd2;
  localparam op_t OP_INC  = 3'd3;
  localparam op_t OP_DEC  = 3'd4;
  localparam op_t OP_SHL  = 3'd5;
  localparam op_t OP_SHR  = 3'd6;
  localparam op_t OP_SWAP = 3'd7;

endpackage

`default_nettype wire

// File: rtl/sap_reg_bank_if.sv
// ---------------------------------------------------------------------------
// sap_reg_bank_if
// Control and data signals between the SAP controller (master) and the
// register bank (slave). The tri-state W-bus output is kept out of this
// interface and stays a plain port on the bank.
// Signals:
//   bus_in  W-bus data for LOAD        wr_sel  target register of op
//   rd_sel  read / SWAP partner select op      operation code
//   oe      bus output enable          a_out   reg[0]
//   b_out   reg[1]                     z_flag  last result == 0
//   c_flag  carry/borrow/shifted-out bit of last op
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface sap_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  import sap_pkg::*;

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] bus_in;
  logic [AW-1:0]    wr_sel;
  logic [AW-1:0]    rd_sel;
  op_t              op;
  logic             oe;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             z_flag;
  logic             c_flag;

  modport master (
    output bus_in, wr_sel, rd_sel, op, oe,
    input  a_out, b_out, z_flag, c_flag
  );

  modport slave (
    input  bus_in, wr_sel, rd_sel, op, oe,
    output a_out, b_out, z_flag, c_flag
  );

endinterface

`default_nettype wire

// File: rtl/sap_reg_op_unit.sv
// ---------------------------------------------------------------------------
// sap_reg_op_unit
// Combinational single-register operation unit: computes the next value of
// the target register and the carry flag for every op except SWAP (which
// involves two registers and is handled by the bank; here it passes tgt).
// Ports:
//   op_i      operation code          tgt_i    current target value
//   bus_in_i  W-bus data for LOAD     nxt_o    next target value
//   carry_o   carry / borrow / shifted-out bit
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sap_reg_op_unit
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] bus_in_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  always_comb begin
    nxt_o   = tgt_i;
    carry_o = 1'b0;
    case (op_i)
      OP_LOAD: nxt_o = bus_in_i;
      OP_CLR:  nxt_o = '0;
      OP_INC: begin
        nxt_o   = tgt_i + C_ONE;
        carry_o = &tgt_i;
      end
      OP_DEC: begin
        nxt_o   = tgt_i - C_ONE;
        carry_o = ~|tgt_i;
      end
      OP_SHL:  {carry_o, nxt_o} = {tgt_i, 1'b0};
      OP_SHR:  {nxt_o, carry_o} = {1'b0, tgt_i};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sap_reg_bank.sv
// ---------------------------------------------------------------------------
// sap_reg_bank
// Parametrised SAP register bank: NREGS registers of WIDTH bits with LOAD,
// CLR, INC, DEC, SHL, SHR and SWAP, registered Z/C flags, tri-state read
// onto the W-bus, and reg[0]/reg[1] permanently exposed as ALU operands.
// Ports:
//   clk      system clock
//   clr      synchronous active-high reset (overrides op)
//   bus      sap_reg_bank_if slave modport (selects, op, oe, operands, flags)
//   bus_out  reg[rd_sel] when oe, else high impedance (0 if rd_sel invalid)
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sap_reg_bank
  import sap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             clr,
  sap_reg_bank_if.slave    bus,
  output wire  [WIDTH-1:0] bus_out
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_rd_val;
  logic [WIDTH-1:0] w_nxt;
  logic             w_carry;

  // Select decode by explicit compare so that selects >= NREGS (possible
  // when NREGS is not a power of two) never index past the array; an
  // invalid select reads as 0 and flags itself as not-ok.
  always_comb begin
    w_wr_ok  = 1'b0;
    w_rd_ok  = 1'b0;
    w_tgt    = '0;
    w_rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wr_sel == AW'(i)) begin
        w_wr_ok = 1'b1;
        w_tgt   = regs_q[i];
      end
      if (bus.rd_sel == AW'(i)) begin
        w_rd_ok  = 1'b1;
        w_rd_val = regs_q[i];
      end
    end
  end

  sap_reg_op_unit #(
    .WIDTH (WIDTH)
  ) u_op_unit (
    .op_i     (bus.op),
    .tgt_i    (w_tgt),
    .bus_in_i (bus.bus_in),
    .nxt_o    (w_nxt),
    .carry_o  (w_carry)
  );

  always_comb begin
    regs_d = regs_q;
    z_d    = z_q;
    c_d    = c_q;
    if (bus.op == OP_SWAP) begin
      // Both selects must be valid; with wr_sel == rd_sel both writes
      // carry the same value, leaving the register unchanged.
      if (w_wr_ok && w_rd_ok) begin
        for (int i = 0; i < NREGS; i++) begin
          if (bus.wr_sel == AW'(i)) regs_d[i] = w_rd_val;
          if (bus.rd_sel == AW'(i)) regs_d[i] = w_tgt;
        end
        z_d = (w_rd_val == '0);
        c_d = 1'b0;
      end
    end else if (bus.op != OP_NOP && w_wr_ok) begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wr_sel == AW'(i)) regs_d[i] = w_nxt;
      end
      z_d = (w_nxt == '0);
      c_d = w_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      z_q <= 1'b1;
      c_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      z_q    <= z_d;
      c_q    <= c_d;
    end
  end

  assign bus.a_out  = regs_q[0];
  assign bus.b_out  = regs_q[1];
  assign bus.z_flag = z_q;
  assign bus.c_flag = c_q;

  // Reads are from current state, so the op cycle shows the pre-op value.
  assign bus_out = bus.oe ? w_rd_val : {WIDTH{1'bz}};

endmodule

`default_nettype wire
